// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared SPART types, register addresses and defaults
package spart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;

    localparam int DEFAULT_OVERSAMPLE = 16;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for an asynchronous input
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/receive.sv
// rtl/receive.sv - SPART serial receiver: 8N1 deserializer with RDA/FE/OVR flags
module receive
    import spart_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Enable,
    input  logic       RxD,
    input  logic       IOCS,
    input  logic       IORW,
    input  logic [1:0] IOADDR,
    output logic [7:0] RX_DATA,
    output logic       RDA,
    output logic       FE,
    output logic       OVR
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);

    logic            resetn;
    logic            rxs;
    rx_state_t       state, state_nxt;
    logic [TW-1:0]   tick;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            mid_hit, end_hit;
    logic            cnt_clr, shift_en, load_byte;
    logic            rd_data, rd_status;

    // Deselecting the chip is treated exactly like a reset.
    assign resetn = rst & IOCS;

    sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (RxD),
        .q      (rxs)
    );

    assign mid_hit   = Enable && (tick == TICK_MID);
    assign end_hit   = Enable && (tick == TICK_END);
    assign rd_data   = IOCS && IORW && (IOADDR == ADDR_DATA);
    assign rd_status = IOCS && IORW && (IOADDR == ADDR_STATUS);

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (Enable && !rxs)              state_nxt = START;
            START: if (mid_hit)                     state_nxt = rxs ? IDLE : DATA;
            DATA:  if (end_hit && bit_cnt == 3'd7)  state_nxt = STOP;
            STOP:  if (end_hit)                     state_nxt = IDLE;
            default:                                state_nxt = IDLE;
        endcase
    end

    // Counters sit at zero in IDLE and restart at the mid-start sample,
    // so later samples land in the middle of each bit cell.
    always_comb begin
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        load_byte = 1'b0;
        case (state)
            IDLE:    cnt_clr   = 1'b1;
            START:   cnt_clr   = mid_hit;
            DATA:    shift_en  = end_hit;
            STOP:    load_byte = end_hit;
            default: cnt_clr   = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tick    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            RX_DATA <= '0;
            RDA     <= 1'b0;
            FE      <= 1'b0;
            OVR     <= 1'b0;
        end else begin
            if (cnt_clr)     tick <= '0;
            else if (Enable) tick <= tick + 1'b1;

            if (cnt_clr)       bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 3'd1;

            if (shift_en) shift <= {rxs, shift[7:1]};

            if (load_byte) begin
                RX_DATA <= shift;
                RDA     <= 1'b1;
                FE      <= !rxs;
                // A concurrent data read consumes the old byte, so no overrun.
                OVR     <= rd_data ? 1'b0 : (OVR | RDA);
            end else begin
                if (rd_data) begin
                    RDA <= 1'b0;
                    OVR <= 1'b0;
                end
                if (rd_status) FE <= 1'b0;
            end
        end
    end

endmodule
